// File: rtl/spi_frame_initiator.sv
// SPI mode-0 initiator: one full-duplex MSB-first frame per start pulse.
// Optional SPI_INIT_LOOPBACK_EN adds loopback_en to sample mosi instead of miso.
module spi_frame_initiator #(
    parameter int CLK_DIV  = 2,
    parameter int DATA_W   = 8,
    parameter int CS_SETUP = 1,
    parameter int CS_HOLD  = 1
) (
    input  logic              clock_in,
    input  logic              rs,
`ifdef SPI_INIT_LOOPBACK_EN
    input  logic              loopback_en,
`endif
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              sclk,
    output logic              cs,
    output logic              mosi,
    input  logic              miso,
    output logic              led
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] XFER  = 3'd2;
    localparam logic [2:0] HOLD  = 3'd3;
    localparam logic [2:0] GAP   = 3'd4;

    localparam int DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int UMAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int UW   = (UMAX > 1) ? $clog2(UMAX) : 1;
    localparam int BW   = $clog2(DATA_W + 1);

    logic [2:0]        state;
    logic [DW-1:0]     div_cnt;
    logic [UW-1:0]     unit_cnt;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-2:0] tx_shift;
    logic [DATA_W-1:0] rx_shift;
    logic              tick;
    logic              sample;

    assign tick = (div_cnt == DW'(CLK_DIV - 1));

`ifdef SPI_INIT_LOOPBACK_EN
    assign sample = loopback_en ? mosi : miso;
`else
    assign sample = miso;
`endif

    always_ff @(posedge clock_in or negedge rs) begin
        if (!rs) begin
            state    <= IDLE;
            div_cnt  <= '0;
            unit_cnt <= '0;
            bit_cnt  <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sclk     <= 1'b0;
            cs       <= 1'b1;
            mosi     <= 1'b0;
            led      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state != IDLE) begin
                div_cnt <= tick ? '0 : div_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        tx_shift <= tx_data[DATA_W-2:0];
                        mosi     <= tx_data[DATA_W-1];
                        cs       <= 1'b0;
                        led      <= 1'b1;
                        busy     <= 1'b1;
                        div_cnt  <= '0;
                        unit_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (tick) begin
                        if (unit_cnt == UW'(CS_SETUP - 1)) begin
                            unit_cnt <= '0;
                            state    <= XFER;
                        end else begin
                            unit_cnt <= unit_cnt + 1'b1;
                        end
                    end
                end
                XFER: begin
                    if (tick) begin
                        sclk <= ~sclk;
                        if (!sclk) begin
                            rx_shift <= {rx_shift[DATA_W-2:0], sample};
                            bit_cnt  <= bit_cnt + 1'b1;
                        end else if (bit_cnt == BW'(DATA_W)) begin
                            // last fall: mosi keeps the LSB through HOLD
                            state <= HOLD;
                        end else begin
                            mosi     <= tx_shift[DATA_W-2];
                            tx_shift <= tx_shift << 1;
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        if (unit_cnt == UW'(CS_HOLD - 1)) begin
                            unit_cnt <= '0;
                            cs       <= 1'b1;
                            led      <= 1'b0;
                            mosi     <= 1'b0;
                            rx_data  <= rx_shift;
                            done     <= 1'b1;
                            state    <= GAP;
                        end else begin
                            unit_cnt <= unit_cnt + 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (tick) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
